// File: rtl/tl_fifo_wr_arb.sv
// Packet-aware round-robin write arbiter for a shared TL FIFO.
// Holds the grant for a whole packet and tracks FIFO occupancy from writes and reads.
module tl_fifo_wr_arb #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int DEPTH_LG2 = 4,
    parameter int AFULL_THR = 12,
    localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CNT_W    = DEPTH_LG2 + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ-1:0]        req_last_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic                    fifo_wren_o,
    output logic [DATA_W-1:0]       fifo_wdata_o,
    input  logic                    fifo_rden_i,
    output logic [CNT_W-1:0]        cnt_o,
    output logic                    full_o,
    output logic                    afull_o,
    output logic                    empty_o,
    output logic                    busy_o,
    output logic [IDX_W-1:0]        grant_idx_o,
    output logic                    underflow_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CAP = CNT_W'(1) << DEPTH_LG2;

    state_t             state_r, state_nxt_s;
    logic [IDX_W-1:0]   grant_r, grant_nxt_s;
    logic [IDX_W-1:0]   rr_ptr_r, rr_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic               underflow_r;
    logic [IDX_W-1:0]   winner_s;
    logic               found_s;
    logic               full_s, empty_s;
    logic               accept_s, rd_s;

    assign full_s   = (cnt_r == CAP);
    assign empty_s  = (cnt_r == CNT_W'(0));
    assign accept_s = (state_r == XFER) & req_valid_i[grant_r] & ~full_s;
    assign rd_s     = fifo_rden_i & ~empty_s;

    assign fifo_wren_o  = accept_s;
    assign fifo_wdata_o = req_data_i[grant_r*DATA_W +: DATA_W];
    assign cnt_o        = cnt_r;
    assign full_o       = full_s;
    assign afull_o      = (cnt_r >= CNT_W'(AFULL_THR));
    assign empty_o      = empty_s;
    assign busy_o       = (state_r == XFER);
    assign grant_idx_o  = grant_r;
    assign underflow_o  = underflow_r;

    // Round-robin winner: first valid requester after the last granted one.
    always_comb begin
        winner_s = '0;
        found_s  = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            int idx;
            idx = (int'(rr_ptr_r) + i) % N_REQ;
            if (!found_s && req_valid_i[IDX_W'(idx)]) begin
                found_s  = 1'b1;
                winner_s = IDX_W'(idx);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Only the granted requester sees ready, and only while the FIFO has room.
    always_comb begin
        req_ready_o = '0;
        if (state_r == XFER) begin
            req_ready_o[grant_r] = ~full_s;
        end else begin
            req_ready_o = '0;
        end
    end

    // Next-state logic: arbitrate in IDLE, release the grant on an accepted last beat.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        rr_nxt_s    = rr_ptr_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_nxt_s = XFER;
                    grant_nxt_s = winner_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            XFER: begin
                if (accept_s && req_last_i[grant_r]) begin
                    state_nxt_s = IDLE;
                    rr_nxt_s    = grant_r;
                end else begin
                    state_nxt_s = XFER;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Occupancy: a simultaneous write and read cancel out.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (accept_s && !rd_s) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else if (rd_s && !accept_s) begin
            cnt_nxt_s = cnt_r - CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // State, grant, round-robin pointer, occupancy and sticky underflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            grant_r     <= '0;
            rr_ptr_r    <= IDX_W'(N_REQ - 1);
            cnt_r       <= '0;
            underflow_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            grant_r     <= grant_nxt_s;
            rr_ptr_r    <= rr_nxt_s;
            cnt_r       <= cnt_nxt_s;
            underflow_r <= underflow_r | (fifo_rden_i & empty_s);
        end
    end

endmodule

// File: tb/tb_tl_fifo_wr_arb.sv
// Self-checking bench for tl_fifo_wr_arb: directed scenarios plus a random phase,
// all compared against a packet-level reference model of the arbiter and FIFO count.
module tb_tl_fifo_wr_arb;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int DL  = 4;
    localparam int AF  = 12;
    localparam int CAP = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_last = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            fifo_wren;
    logic [DW-1:0]   fifo_wdata;
    logic            fifo_rden = 1'b0;
    logic [DL:0]     cnt;
    logic            full, afull, empty, busy, underflow;
    logic [1:0]      grant_idx;

    tl_fifo_wr_arb #(.N_REQ(N), .DATA_W(DW), .DEPTH_LG2(DL), .AFULL_THR(AF)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_last_i(req_last), .req_data_i(req_data),
        .req_ready_o(req_ready), .fifo_wren_o(fifo_wren), .fifo_wdata_o(fifo_wdata),
        .fifo_rden_i(fifo_rden), .cnt_o(cnt), .full_o(full), .afull_o(afull),
        .empty_o(empty), .busy_o(busy), .grant_idx_o(grant_idx), .underflow_o(underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: packet owner, last winner, item count, sticky underflow.
    int mcnt, mrr, mg;
    bit mbusy, munder;
    int grants[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_data();
        for (int k = 0; k < N; k++) req_data[k*DW +: DW] = $urandom;
    endtask

    // One clock: check all outputs against the model, then advance the model at the edge.
    task automatic cycle();
        bit          mfull, wr;
        int          rd;
        logic [N-1:0] exp_ready;
        #1;
        mfull     = (mcnt == CAP);
        exp_ready = (mbusy && !mfull) ? N'(1 << mg) : '0;
        wr        = mbusy && req_valid[mg] && !mfull;
        chk("ready", req_ready, exp_ready);
        chk("wren", fifo_wren, wr);
        chk("cnt", cnt, mcnt);
        chk("full", full, mfull);
        chk("afull", afull, mcnt >= AF);
        chk("empty", empty, mcnt == 0);
        chk("busy", busy, mbusy);
        chk("grant", grant_idx, mg);
        chk("underflow", underflow, munder);
        if (wr) begin
            chk("wdata", fifo_wdata, req_data[mg*DW +: DW]);
            grants.push_back(mg);
        end
        @(posedge clk);
        rd = (fifo_rden && mcnt != 0) ? 1 : 0;
        if (fifo_rden && mcnt == 0) munder = 1'b1;
        mcnt = mcnt + int'(wr) - rd;
        if (!mbusy) begin
            if (req_valid != '0) begin
                for (int k = 1; k <= N; k++) begin
                    if (req_valid[(mrr + k) % N]) begin
                        mg = (mrr + k) % N;
                        break;
                    end
                end
                mbusy = 1'b1;
            end
        end else if (wr && req_last[mg]) begin
            mrr   = mg;
            mbusy = 1'b0;
        end
        #1;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        req_valid = '0;
        req_last  = '0;
        fifo_rden = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_cnt", cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_wren", fifo_wren, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_afull", afull, 0);
        chk("rst_grant", grant_idx, 0);
        chk("rst_underflow", underflow, 0);
        mcnt = 0; mrr = N - 1; mg = 0; mbusy = 1'b0; munder = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_until_cnt(input int target, input int budget);
        int n = 0;
        while (mcnt != target && n < budget) begin
            new_data();
            cycle();
            n++;
        end
        chk("reach_cnt", cnt, target);
    endtask

    initial begin
        #2;
        do_reset();

        // Single requester, 3-beat packet.
        req_valid = 4'b0010; new_data(); cycle();
        chk("t1_busy", busy, 1);
        new_data(); cycle();
        new_data(); cycle();
        req_last = 4'b0010; new_data(); cycle();
        req_valid = 4'b0000; req_last = 4'b0000; cycle();
        chk("t1_cnt", cnt, 3);
        chk("t1_idle", busy, 0);
        fifo_rden = 1'b1; run_until_cnt(0, 10); fifo_rden = 1'b0;

        // Round-robin fairness with 1-beat packets.
        do_reset();
        grants.delete();
        req_valid = 4'b1111; req_last = 4'b1111; fifo_rden = 1'b1;
        for (int i = 0; i < 10; i++) begin new_data(); cycle(); end
        chk("rr_writes", grants.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("rr_order", (grants.size() > i) ? grants[i] : -1, i % N);
        req_valid = '0; req_last = '0;
        run_until_cnt(0, 10); fifo_rden = 1'b0;

        // Packet lock: req 2 owns the FIFO through a bubble while req 0 waits.
        do_reset();
        req_valid = 4'b0100; new_data(); cycle();
        for (int i = 0; i < 5; i++) begin
            req_valid = (i == 2) ? 4'b0001 : 4'b0101;
            req_last  = (i == 4) ? 4'b0100 : 4'b0000;
            new_data();
            #1 chk("lock_ready0", req_ready[0], 0);
            cycle();
        end
        req_valid = 4'b0001; req_last = 4'b0001; new_data(); cycle();
        new_data();
        #1 chk("lock_next_grant", grant_idx, 0);
        chk("lock_next_ready", req_ready, 4'b0001);
        cycle();
        req_valid = '0; req_last = '0; cycle();
        fifo_rden = 1'b1; run_until_cnt(0, 10); fifo_rden = 1'b0;

        // Full, almost-full and read-at-full behaviour.
        do_reset();
        req_valid = 4'b0001;
        run_until_cnt(11, 20);
        chk("afull_below", afull, 0);
        run_until_cnt(12, 5);
        chk("afull_at_thr", afull, 1);
        run_until_cnt(16, 10);
        new_data(); cycle(); new_data(); cycle();
        chk("full_flag", full, 1);
        chk("full_ready", req_ready, 0);
        fifo_rden = 1'b1; new_data();
        #1 chk("full_rd_no_wr", fifo_wren, 0);
        cycle();
        fifo_rden = 1'b0;
        chk("full_after_rd", cnt, 15);
        chk("ready_returns", req_ready, 4'b0001);
        req_last = 4'b0001; new_data(); cycle();
        req_valid = '0; req_last = '0;
        chk("refilled", cnt, 16);
        fifo_rden = 1'b1; run_until_cnt(0, 20); fifo_rden = 1'b0;

        // Simultaneous read and write, then read at empty.
        do_reset();
        req_valid = 4'b0001;
        run_until_cnt(5, 15);
        fifo_rden = 1'b1; req_last = 4'b0001; new_data(); cycle();
        chk("rw_hold", cnt, 5);
        req_valid = '0; req_last = '0;
        run_until_cnt(0, 10);
        cycle();
        fifo_rden = 1'b0;
        chk("empty_rd_cnt", cnt, 0);
        chk("underflow_set", underflow, 1);
        cycle(); cycle();
        chk("underflow_sticky", underflow, 1);

        // Async reset mid-packet at cnt 7.
        do_reset();
        req_valid = 4'b0010;
        run_until_cnt(7, 15);
        chk("pre_reset_busy", busy, 1);
        do_reset();
        req_valid = 4'b0011; req_last = 4'b0011; new_data(); cycle();
        new_data();
        #1 chk("post_reset_grant", grant_idx, 0);
        chk("post_reset_ready", req_ready, 4'b0001);
        cycle();
        req_valid = '0; req_last = '0; cycle();

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            req_valid = N'($urandom);
            req_last  = N'($urandom);
            fifo_rden = ($urandom_range(0, 99) < ((i < 300) ? 25 : 70));
            new_data();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tl_fifo_wr_arb.md
Name: tl_fifo_wr_arb

Overview:
- Packet-aware round-robin write arbiter that shares one TL FIFO among N_REQ requesters.
- Grants one requester at a time and holds the grant until that requester's last beat.
- Drives FIFO write enable and write data, and tracks FIFO occupancy internally from accepted writes and consumer reads.
- Sits between the TL packet sources and the shared FIFO. Provides full, almost-full and empty status to the rest of the TL.

Parameters:
- N_REQ, 4, number of write requesters (at least 2).
- DATA_W, 32, beat width in bits.
- DEPTH_LG2, 4, log2 of FIFO capacity; CAP = 2**DEPTH_LG2 = 16.
- AFULL_THR, 12, afull_o asserts when occupancy >= AFULL_THR (1..CAP).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  N_REQ  per-requester beat valid
- req_last_i  in  N_REQ  per-requester last beat of packet
- req_data_i  in  N_REQ*DATA_W  per-requester beat data; requester k uses bits [k*DATA_W +: DATA_W]
- req_ready_o  out  N_REQ  per-requester beat accepted this cycle when valid is also high
- fifo_wren_o  out  1  FIFO write enable
- fifo_wdata_o  out  DATA_W  FIFO write data
- fifo_rden_i  in  1  FIFO consumer read strobe
- cnt_o  out  DEPTH_LG2+1  current occupancy, 0..CAP
- full_o  out  1  cnt_o == CAP
- afull_o  out  1  cnt_o >= AFULL_THR
- empty_o  out  1  cnt_o == 0
- busy_o  out  1  FSM in XFER
- grant_idx_o  out  $clog2(N_REQ)  current or last grant index
- underflow_o  out  1  sticky: fifo_rden_i seen while empty

Behaviour:
- Reset (async, rst_n low):
  - FSM = IDLE; cnt = 0; rr_ptr = N_REQ-1, so requester 0 has highest priority first.
  - grant_idx_o = 0; underflow_o = 0.
  - Resulting outputs: req_ready_o = 0, fifo_wren_o = 0, busy_o = 0, empty_o = 1, full_o = 0, afull_o = 0.
- FSM IDLE:
  - req_ready_o all 0.
  - If any req_valid_i is set, choose the winner as the first set bit searching from (rr_ptr+1) mod N_REQ upward, with wrap.
  - Register the winner into grant_idx_o and go to XFER.
  - Arbitration latency is 1 cycle: the first beat can be accepted at the earliest in the cycle after the request is seen.
- FSM XFER with grant g:
  - req_ready_o[g] = ~full_o; all other ready bits are 0.
  - A beat is accepted when req_valid_i[g] & req_ready_o[g].
  - fifo_wren_o equals beat acceptance combinationally, same cycle. fifo_wdata_o = data slice g.
  - Valid bubbles mid-packet are allowed; the grant is held.
  - An accepted beat with req_last_i[g] high: rr_ptr <= g, next state IDLE. This gives one mandatory idle cycle between packets.
- Occupancy counter:
  - wr = fifo_wren_o; rd = fifo_rden_i & ~empty_o.
  - wr only: cnt+1. rd only: cnt-1. Both or neither: hold.
- Full:
  - No write is accepted when cnt == CAP, even if a read occurs the same cycle (no bypass).
  - Ready reasserts the cycle after cnt drops below CAP.
- Empty read:
  - fifo_rden_i while empty does not change cnt and sets underflow_o, which is cleared only by reset.
- Status outputs:
  - cnt_o, full_o, afull_o and empty_o are decoded from the registered cnt. They reflect the previous cycle's updates.
- Reset mid-packet:
  - Returns to IDLE immediately and clears cnt.
  - The partial packet is abandoned. The FIFO storage is reset in the same domain.
- Requesters other than g:
  - Their valid and last inputs are ignored while in XFER; they wait with valid held.
- Width rules:
  - cnt is DEPTH_LG2+1 bits, so CAP is representable and there is no wrap.
  - The round-robin index computation wraps modulo N_REQ.

Test Plan:
- Single requester:
  - Stimulus: req 1 sends a 3-beat packet into the empty FIFO.
  - Required: busy_o high from cycle 1; beats written in cycles 1-3 with fifo_wdata_o = req 1 data; cnt_o = 3; back to IDLE.
- Round-robin fairness:
  - Stimulus: all 4 requesters hold valid with 1-beat packets.
  - Required: grant order 0,1,2,3,0; exactly one write every 2 cycles.
- Packet lock:
  - Stimulus: req 2 sends a 4-beat packet with a valid bubble after beat 2, while req 0 is valid throughout.
  - Required: req 0 gets no ready until req 2's last beat is accepted; req 0 is granted next.
- Full:
  - Stimulus: fill to 16 with no reads.
  - Required: full_o = 1, req_ready_o = 0, afull_o was set at cnt 12. A single read then gives cnt 15 and ready returns the next cycle. A simultaneous read plus valid at full writes nothing.
- Simultaneous read and write:
  - Stimulus: at cnt 5, a write and a read in the same cycle.
  - Required: cnt stays 5.
  - Stimulus: read at cnt 0.
  - Required: cnt stays 0 and underflow_o = 1 persistently.
- Async reset:
  - Stimulus: assert rst_n mid-packet at cnt 7.
  - Required: immediately cnt_o = 0, busy_o = 0, req_ready_o = 0. After release, req 0 has priority.
